// File: rtl/timer_pkg.sv
// Shared time-of-day types and field limits for the clock and alarm blocks.
package timer_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;
    localparam int SEC_PER_MIN   = 60;

    typedef logic [4:0] hour_t;
    typedef logic [5:0] min_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } mode_t;

    // Minutes and seconds share one wrap helper; the modulus picks the field.
    function automatic min_t incMin(input min_t v, input int modulus);
        return (v == min_t'(modulus - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic hour_t incHour(input hour_t v);
        return (v == hour_t'(HOURS_PER_DAY - 1)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides mclk down to a one-cycle sec_tick; cleared and held while run is low.
module sec_prescaler #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic run,
    output logic sec_tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign sec_tick = run && (count == LAST);

endmodule

// File: rtl/tod_counter.sv
// 24 h time-of-day counter with button-driven hour/minute set mode and a
// registered minute-rollover pulse.
module tod_counter
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output hour_t      nowH,
    output min_t       nowM,
    output min_t       nowS,
    output logic       min_tick,
    output logic [1:0] mode
);

    mode_t state, stateNext;
    hour_t hNext;
    min_t  mNext, sNext;
    logic  tickNext;
    logic  secTick;

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .run     (state == RUN),
        .sec_tick(secTick)
    );

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            nowH     <= '0;
            nowM     <= '0;
            nowS     <= '0;
            min_tick <= 1'b0;
        end else begin
            state    <= stateNext;
            nowH     <= hNext;
            nowM     <= mNext;
            nowS     <= sNext;
            min_tick <= tickNext;
        end
    end

    // A mode press always wins over a pending tick or increment in the same cycle.
    always_comb begin
        stateNext = state;
        hNext     = nowH;
        mNext     = nowM;
        sNext     = nowS;
        tickNext  = 1'b0;
        case (state)
            RUN: begin
                if (btn_mode) begin
                    stateNext = SET_H;
                end else if (secTick) begin
                    sNext = incMin(nowS, SEC_PER_MIN);
                    if (nowS == min_t'(SEC_PER_MIN - 1)) begin
                        mNext    = incMin(nowM, MIN_PER_HOUR);
                        tickNext = 1'b1;
                        if (nowM == min_t'(MIN_PER_HOUR - 1)) begin
                            hNext = incHour(nowH);
                        end
                    end
                end
            end
            SET_H: begin
                if (btn_mode) begin
                    stateNext = SET_M;
                end else if (btn_inc) begin
                    hNext = incHour(nowH);
                end
            end
            SET_M: begin
                if (btn_mode) begin
                    stateNext = RUN;
                    sNext     = '0;
                end else if (btn_inc) begin
                    mNext = incMin(nowM, MIN_PER_HOUR);
                end
            end
            default: stateNext = RUN;
        endcase
    end

    assign mode = state;

endmodule
